// File: rtl/fpga_arduino_pkg.sv
// Shared definitions for the FPGA -> Arduino game-event link.
// Contents: sync nibble, message-type codes, TX state enum and the packet
// builder used by the serializer.
package fpga_arduino_pkg;

  localparam logic [3:0] SYNC_NIBBLE  = 4'hA;

  localparam logic [3:0] MSG_SLICE    = 4'd1;
  localparam logic [3:0] MSG_SCORE    = 4'd2;
  localparam logic [3:0] MSG_STREAK   = 4'd3;
  localparam logic [3:0] MSG_LIVES    = 4'd4;
  localparam logic [3:0] MSG_GAMEOVER = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4
  } tx_state_t;

  // Packet word {sync, type, payload, chk}; chk is the 8-bit wrapping sum of
  // the header byte and both payload bytes.
  function automatic logic [31:0] build_packet(input logic [3:0]  typ,
                                               input logic [15:0] payload);
    logic [7:0] chk;
    chk = {SYNC_NIBBLE, typ} + payload[15:8] + payload[7:0];
    return {SYNC_NIBBLE, typ, payload, chk};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a single-cycle pulse
// on each synchronized rising edge.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   din          : asynchronous input
//   rise         : one-cycle pulse per rising edge of din (after sync delay)
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  // sr[0] may go metastable, sr[1] is the synchronized value, sr[2] its history
  logic [2:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/fpga_arduino_tx.sv
// Serializes game-event packets to the Arduino over a source-synchronous
// three-wire link (tx_clk / tx_data / tx_frame_n), MSB first, then waits for
// an ack edge and resends on timeout.
// Ports:
//   clk, reset_n          : system clock, async active-low reset
//   msg_valid/msg_ready   : producer handshake, accept on valid & ready
//   msg_type, msg_payload : message contents, latched on accept
//   ack_in                : asynchronous ack line, rising edge = ack
//   tx_clk, tx_data       : serial clock (idles low) and data
//   tx_frame_n            : low while a packet is on the wire
//   busy                  : high whenever not idle
//   tx_done, tx_error     : one-cycle completion / retries-exhausted pulses
//   err_count             : saturating count of tx_error pulses
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a message
// LOAD     | build packet word, clear retry count
// SHIFT    | 32 bits, each CLK_DIV cycles low then CLK_DIV cycles high
// WAIT_ACK | wait up to ACK_TIMEOUT cycles for an ack edge
// GAP      | frame-high spacing of 2*CLK_DIV (retry, or done when no ack)
module fpga_arduino_tx
  import fpga_arduino_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int ACK_EN      = 1,
  parameter int ACK_TIMEOUT = 5000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [3:0]  msg_type,
  input  logic [15:0] msg_payload,
  input  logic        ack_in,
  output logic        tx_clk,
  output logic        tx_data,
  output logic        tx_frame_n,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_error,
  output logic [7:0]  err_count
);

  // One down-counter serves the half-bit, gap and ack-timeout intervals.
  localparam int TMR_MAX = (2 * CLK_DIV > ACK_TIMEOUT) ? 2 * CLK_DIV : ACK_TIMEOUT;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0]   DIV_LOAD   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]   GAP_LOAD   = TMR_W'(2 * CLK_DIV - 1);
  localparam logic [TMR_W-1:0]   TMO_LOAD   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   POST_LOAD  = (ACK_EN != 0) ? TMO_LOAD : GAP_LOAD;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  tx_state_t           state, next_state;
  logic [TMR_W-1:0]    tmr;
  logic                ph_hi;
  logic [4:0]          bit_cnt;
  logic [31:0]         sh;
  logic [RETRY_W-1:0]  retry_cnt;
  logic [3:0]          type_q;
  logic [15:0]         payload_q;
  logic                ack_rise;
  logic                tmr_zero;
  logic                retry_left;
  logic                last_bit_end;

  sync_edge_detect u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ack_in),
    .rise    (ack_rise)
  );

  assign tmr_zero     = (tmr == '0);
  assign retry_left   = (retry_cnt != RETRY_LAST);
  assign last_bit_end = tmr_zero && ph_hi && (bit_cnt == 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (msg_valid) next_state = ST_LOAD;
      ST_LOAD:     next_state = ST_SHIFT;
      ST_SHIFT:    if (last_bit_end) next_state = (ACK_EN != 0) ? ST_WAIT_ACK : ST_GAP;
      ST_WAIT_ACK: begin
        // ack is checked first so a same-cycle ack beats the timeout
        if (ack_rise)      next_state = ST_IDLE;
        else if (tmr_zero) next_state = retry_left ? ST_GAP : ST_IDLE;
      end
      ST_GAP:      if (tmr_zero) next_state = (ACK_EN != 0) ? ST_SHIFT : ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    msg_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    tx_frame_n = (state != ST_SHIFT);
    tx_clk     = (state == ST_SHIFT) && ph_hi;
    tx_data    = (state == ST_SHIFT) && sh[31];
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    case (state)
      ST_WAIT_ACK: begin
        if (ack_rise)                     tx_done  = 1'b1;
        else if (tmr_zero && !retry_left) tx_error = 1'b1;
      end
      ST_GAP:      if (tmr_zero && (ACK_EN == 0)) tx_done = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr       <= '0;
      ph_hi     <= 1'b0;
      bit_cnt   <= 5'd0;
      sh        <= '0;
      retry_cnt <= '0;
      type_q    <= '0;
      payload_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (msg_valid) begin
            type_q    <= msg_type;
            payload_q <= msg_payload;
          end
        end
        ST_LOAD: begin
          retry_cnt <= '0;
          sh        <= build_packet(type_q, payload_q);
          tmr       <= DIV_LOAD;
          ph_hi     <= 1'b0;
          bit_cnt   <= 5'd31;
        end
        ST_SHIFT: begin
          if (!tmr_zero) begin
            tmr <= tmr - 1'b1;
          end else if (!ph_hi) begin
            ph_hi <= 1'b1;
            tmr   <= DIV_LOAD;
          end else if (bit_cnt != 5'd0) begin
            // next bit is presented together with the falling tx_clk
            ph_hi   <= 1'b0;
            bit_cnt <= bit_cnt - 1'b1;
            sh      <= {sh[30:0], 1'b0};
            tmr     <= DIV_LOAD;
          end else begin
            ph_hi <= 1'b0;
            tmr   <= POST_LOAD;
          end
        end
        ST_WAIT_ACK: begin
          if (!tmr_zero) begin
            tmr <= tmr - 1'b1;
          end else if (!ack_rise && retry_left) begin
            retry_cnt <= retry_cnt + 1'b1;
            tmr       <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (!tmr_zero) begin
            tmr <= tmr - 1'b1;
          end else begin
            // a retry resends the identical word from the latched message
            sh      <= build_packet(type_q, payload_q);
            tmr     <= DIV_LOAD;
            ph_hi   <= 1'b0;
            bit_cnt <= 5'd31;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= 8'd0;
    end else if (tx_error && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fpga_arduino_tx.sv
module tb_fpga_arduino_tx;
  import fpga_arduino_pkg::*;

  localparam int CLK_DIV     = 2;
  localparam int ACK_TIMEOUT = 40;
  localparam int MAX_RETRY   = 2;
  localparam int FRAME_CYC   = 64 * CLK_DIV;
  // retry: full ack window, then the GAP, then straight back into SHIFT
  localparam int RETRY_GAP   = ACK_TIMEOUT + 2 * CLK_DIV;
  // no-ack mode: GAP, then one IDLE (accept) cycle and one LOAD cycle
  localparam int NOACK_GAP   = 2 * CLK_DIV + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_ack = 0;
  logic [3:0]  a_type = 0;
  logic [15:0] a_payload = 0;
  logic        a_ready, a_tx_clk, a_tx_data, a_tx_frame_n, a_busy, a_tx_done, a_tx_error;
  logic [7:0]  a_err_count;

  logic        b_valid = 0, b_ack = 0;
  logic [3:0]  b_type = 0;
  logic [15:0] b_payload = 0;
  logic        b_ready, b_tx_clk, b_tx_data, b_tx_frame_n, b_busy, b_tx_done, b_tx_error;
  logic [7:0]  b_err_count;

  logic        s_valid = 0, s_ack = 0;
  logic [3:0]  s_type = 0;
  logic [15:0] s_payload = 0;
  logic        s_ready, s_tx_clk, s_tx_data, s_tx_frame_n, s_busy, s_tx_done, s_tx_error;
  logic [7:0]  s_err_count;

  fpga_arduino_tx #(.CLK_DIV(CLK_DIV), .ACK_EN(1), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut_a (
    .clk(clk), .reset_n(reset_n), .msg_valid(a_valid), .msg_ready(a_ready), .msg_type(a_type),
    .msg_payload(a_payload), .ack_in(a_ack), .tx_clk(a_tx_clk), .tx_data(a_tx_data),
    .tx_frame_n(a_tx_frame_n), .busy(a_busy), .tx_done(a_tx_done), .tx_error(a_tx_error),
    .err_count(a_err_count));

  fpga_arduino_tx #(.CLK_DIV(CLK_DIV), .ACK_EN(0), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut_b (
    .clk(clk), .reset_n(reset_n), .msg_valid(b_valid), .msg_ready(b_ready), .msg_type(b_type),
    .msg_payload(b_payload), .ack_in(b_ack), .tx_clk(b_tx_clk), .tx_data(b_tx_data),
    .tx_frame_n(b_tx_frame_n), .busy(b_busy), .tx_done(b_tx_done), .tx_error(b_tx_error),
    .err_count(b_err_count));

  // fast instance with no retries, used to reach err_count saturation quickly
  fpga_arduino_tx #(.CLK_DIV(1), .ACK_EN(1), .ACK_TIMEOUT(2), .MAX_RETRY(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .msg_valid(s_valid), .msg_ready(s_ready), .msg_type(s_type),
    .msg_payload(s_payload), .ack_in(s_ack), .tx_clk(s_tx_clk), .tx_data(s_tx_data),
    .tx_frame_n(s_tx_frame_n), .busy(s_busy), .tx_done(s_tx_done), .tx_error(s_tx_error),
    .err_count(s_err_count));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference packet: header byte is 0xA0 + type, checksum is the byte sum mod 256.
  function automatic logic [31:0] model_word(input int t, input int p);
    int c;
    c = (160 + t + p / 256 + p % 256) % 256;
    return 32'hA0000000 | (32'(t) << 24) | (32'(p) << 8) | 32'(c);
  endfunction

  // ---------------- line monitors (sample on the falling clk edge) ----------
  logic [31:0] a_words[$];
  int          a_lens[$];
  int          a_bits[$];
  int          a_done_cnt = 0, a_err_cnt = 0, a_idle_viol = 0, a_gap = 0;
  int          a_len = 0, a_nbits = 0, a_hi = 0;
  logic [31:0] a_sr = '0;
  logic        a_prev_clk = 0, a_prev_fn = 1;

  initial forever begin
    @(negedge clk);
    if (a_tx_done)  a_done_cnt++;
    if (a_tx_error) a_err_cnt++;
    if (!a_tx_frame_n && a_prev_fn) begin
      a_gap = a_hi; a_len = 0; a_nbits = 0; a_sr = '0;
    end
    if (a_tx_frame_n && !a_prev_fn) begin
      a_words.push_back(a_sr); a_lens.push_back(a_len); a_bits.push_back(a_nbits); a_hi = 0;
    end
    if (!a_tx_frame_n) begin
      a_len++;
      if (a_tx_clk && !a_prev_clk) begin a_sr = {a_sr[30:0], a_tx_data}; a_nbits++; end
    end else begin
      a_hi++;
      if (a_tx_clk || a_tx_data) a_idle_viol++;
    end
    a_prev_clk = a_tx_clk;
    a_prev_fn  = a_tx_frame_n;
  end

  logic [31:0] b_words[$];
  int          b_lens[$];
  int          b_done_cnt = 0, b_err_cnt = 0, b_idle_viol = 0, b_gap = 0;
  int          b_len = 0, b_hi = 0;
  logic [31:0] b_sr = '0;
  logic        b_prev_clk = 0, b_prev_fn = 1;

  initial forever begin
    @(negedge clk);
    if (b_tx_done)  b_done_cnt++;
    if (b_tx_error) b_err_cnt++;
    if (!b_tx_frame_n && b_prev_fn) begin
      b_gap = b_hi; b_len = 0; b_sr = '0;
    end
    if (b_tx_frame_n && !b_prev_fn) begin
      b_words.push_back(b_sr); b_lens.push_back(b_len); b_hi = 0;
    end
    if (!b_tx_frame_n) begin
      b_len++;
      if (b_tx_clk && !b_prev_clk) b_sr = {b_sr[30:0], b_tx_data};
    end else begin
      b_hi++;
      if (b_tx_clk || b_tx_data) b_idle_viol++;
    end
    b_prev_clk = b_tx_clk;
    b_prev_fn  = b_tx_frame_n;
  end

  int s_done_cnt = 0, s_err_cnt = 0, s_idle_viol = 0;
  initial forever begin
    @(negedge clk);
    if (s_tx_done)  s_done_cnt++;
    if (s_tx_error) s_err_cnt++;
    if (s_tx_frame_n && (s_tx_clk || s_tx_data)) s_idle_viol++;
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_a(input logic [3:0] t, input logic [15:0] p);
    step();
    for (int i = 0; i < 400 && !a_ready; i++) step();
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL send_ready: msg_ready=%b required 1", a_ready);
    end
    a_type = t; a_payload = p; a_valid = 1'b1;
    step();
    // scramble the inputs after accept; the packet must use the latched copy
    a_valid = 1'b0; a_type = 4'($urandom); a_payload = 16'($urandom);
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({a_tx_clk, a_tx_data, a_tx_frame_n, a_busy, a_tx_done, a_tx_error, a_ready} !== 7'b0010001) begin
      n_fail++; $display("FAIL reset_outputs_a: clk,data,frame_n,busy,done,err,ready=%b required 0010001",
        {a_tx_clk, a_tx_data, a_tx_frame_n, a_busy, a_tx_done, a_tx_error, a_ready});
    end
    n_checks++;
    if (a_err_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_err_count: got %0d required 0", a_err_count);
    end
    n_checks++;
    if ({b_tx_clk, b_tx_data, b_tx_frame_n, b_busy, b_tx_done, b_tx_error, b_ready} !== 7'b0010001) begin
      n_fail++; $display("FAIL reset_outputs_b: got %b required 0010001",
        {b_tx_clk, b_tx_data, b_tx_frame_n, b_busy, b_tx_done, b_tx_error, b_ready});
    end
    reset_n = 1'b1;
    repeat (4) step();
    n_checks++;
    if ({a_busy, a_ready, a_tx_frame_n} !== 3'b011) begin
      n_fail++; $display("FAIL idle_after_reset: busy,ready,frame_n=%b required 011", {a_busy, a_ready, a_tx_frame_n});
    end
  endtask

  task automatic test_basic();
    int w0, d0;
    logic [31:0] exp;
    w0 = a_words.size(); d0 = a_done_cnt;
    exp = model_word(int'(MSG_STREAK), 16'h1234);
    send_a(MSG_STREAK, 16'h1234);
    for (int i = 0; i < 400 && a_words.size() == w0; i++) step();
    n_checks++;
    if (a_words.size() != w0 + 1) begin
      n_fail++; $display("FAIL basic_frame_count: got %0d frames required 1", a_words.size() - w0);
    end else begin
      n_checks++;
      if (a_words[w0] !== exp) begin
        n_fail++; $display("FAIL basic_word: got %h required %h", a_words[w0], exp);
      end
      n_checks++;
      if (a_lens[w0] != FRAME_CYC) begin
        n_fail++; $display("FAIL basic_frame_len: got %0d required %0d", a_lens[w0], FRAME_CYC);
      end
      n_checks++;
      if (a_bits[w0] != 32) begin
        n_fail++; $display("FAIL basic_rise_count: got %0d required 32", a_bits[w0]);
      end
    end
    repeat (5) step();
    n_checks++;
    if (a_done_cnt != d0) begin
      n_fail++; $display("FAIL basic_done_before_ack: got %0d pulses required 0", a_done_cnt - d0);
    end
    a_ack = 1'b1;
    for (int i = 0; i < 20 && !a_tx_done; i++) step();
    n_checks++;
    if (a_tx_done !== 1'b1 || a_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_ack_done: done=%b ready=%b required done=1 ready=0", a_tx_done, a_ready);
    end
    step();
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready_after_done: got %b required 1", a_ready);
    end
    a_ack = 1'b0;
    repeat (3) step();
    n_checks++;
    if (a_done_cnt != d0 + 1) begin
      n_fail++; $display("FAIL basic_done_once: got %0d pulses required 1", a_done_cnt - d0);
    end
  endtask

  task automatic test_ack_in_shift();
    int w0, d0, e0;
    logic [7:0] ec0;
    logic [3:0] t;
    logic [15:0] p;
    logic [31:0] exp;
    t = 4'($urandom_range(0, 15)); p = 16'($urandom);
    exp = model_word(int'(t), int'(p));
    w0 = a_words.size(); d0 = a_done_cnt; e0 = a_err_cnt; ec0 = a_err_count;
    send_a(t, p);
    for (int i = 0; i < 50 && a_tx_frame_n; i++) step();
    for (int i = 0; i < 200 && a_nbits < 10; i++) step();
    a_ack = 1'b1;
    repeat (3) step();
    a_ack = 1'b0;
    for (int i = 0; i < 2000 && a_err_cnt == e0; i++) step();
    step();
    n_checks++;
    if (a_err_cnt != e0 + 1) begin
      n_fail++; $display("FAIL shiftack_error_pulse: got %0d pulses required 1", a_err_cnt - e0);
    end
    n_checks++;
    if (a_words.size() != w0 + 3) begin
      n_fail++; $display("FAIL shiftack_frames: got %0d required 3", a_words.size() - w0);
    end
    for (int k = w0; k < a_words.size(); k++) begin
      n_checks++;
      if (a_words[k] !== exp) begin
        n_fail++; $display("FAIL shiftack_word%0d: got %h required %h", k - w0, a_words[k], exp);
      end
    end
    n_checks++;
    if (a_done_cnt != d0) begin
      n_fail++; $display("FAIL shiftack_no_done: got %0d pulses required 0", a_done_cnt - d0);
    end
    n_checks++;
    if (a_err_count !== ec0 + 8'd1) begin
      n_fail++; $display("FAIL shiftack_err_count: got %0d required %0d", a_err_count, ec0 + 8'd1);
    end
    n_checks++;
    if (a_gap != RETRY_GAP) begin
      n_fail++; $display("FAIL retry_gap: got %0d cycles required %0d", a_gap, RETRY_GAP);
    end
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_error: got %b required 1", a_ready);
    end
  endtask

  task automatic test_retry_success();
    int w0, d0, e0;
    logic [7:0] ec0;
    logic [3:0] t;
    logic [15:0] p;
    logic [31:0] exp;
    t = MSG_SCORE; p = 16'($urandom);
    exp = model_word(int'(t), int'(p));
    w0 = a_words.size(); d0 = a_done_cnt; e0 = a_err_cnt; ec0 = a_err_count;
    send_a(t, p);
    for (int i = 0; i < 800 && a_words.size() < w0 + 2; i++) step();
    repeat (4) step();
    a_ack = 1'b1;
    for (int i = 0; i < 20 && a_done_cnt == d0; i++) step();
    a_ack = 1'b0;
    repeat (60) step();
    n_checks++;
    if (a_words.size() != w0 + 2) begin
      n_fail++; $display("FAIL retry_frames: got %0d required 2", a_words.size() - w0);
    end
    for (int k = w0; k < a_words.size(); k++) begin
      n_checks++;
      if (a_words[k] !== exp) begin
        n_fail++; $display("FAIL retry_word%0d: got %h required %h", k - w0, a_words[k], exp);
      end
    end
    n_checks++;
    if (a_done_cnt != d0 + 1 || a_err_cnt != e0) begin
      n_fail++; $display("FAIL retry_pulses: done=%0d err=%0d required done=1 err=0", a_done_cnt - d0, a_err_cnt - e0);
    end
    n_checks++;
    if (a_err_count !== ec0) begin
      n_fail++; $display("FAIL retry_err_count: got %0d required %0d", a_err_count, ec0);
    end
  endtask

  task automatic test_random_packets();
    int w0, d0, dly;
    logic [3:0] t;
    logic [15:0] p;
    logic [31:0] exp;
    for (int n = 0; n < 6; n++) begin
      t = 4'($urandom_range(0, 15)); p = 16'($urandom);
      dly = int'($urandom_range(1, 20));
      exp = model_word(int'(t), int'(p));
      w0 = a_words.size(); d0 = a_done_cnt;
      send_a(t, p);
      for (int i = 0; i < 400 && a_words.size() == w0; i++) step();
      repeat (dly) step();
      a_ack = 1'b1;
      for (int i = 0; i < 20 && a_done_cnt == d0; i++) step();
      a_ack = 1'b0;
      repeat (3) step();
      n_checks++;
      if (a_words.size() != w0 + 1 || a_words[a_words.size() - 1] !== exp) begin
        n_fail++; $display("FAIL random_word%0d: got %h (%0d frames) required %h", n,
          a_words[a_words.size() - 1], a_words.size() - w0, exp);
      end
      n_checks++;
      if (a_done_cnt != d0 + 1) begin
        n_fail++; $display("FAIL random_done%0d: got %0d pulses required 1", n, a_done_cnt - d0);
      end
    end
    n_checks++;
    if (a_idle_viol != 0) begin
      n_fail++; $display("FAIL idle_lines_a: %0d cycles with clk/data high outside frame, required 0", a_idle_viol);
    end
  endtask

  task automatic test_no_ack();
    int w0, d0, e0;
    logic [31:0] exp0, exp1;
    exp0 = model_word(2, 16'h0001);
    exp1 = model_word(2, 16'hFFFF);
    w0 = b_words.size(); d0 = b_done_cnt; e0 = b_err_cnt;
    step();
    b_type = MSG_SCORE; b_payload = 16'h0001; b_valid = 1'b1;
    step();
    b_payload = 16'hFFFF;
    for (int i = 0; i < 400 && b_done_cnt == d0; i++) step();
    n_checks++;
    if (b_tx_done !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL noack_first_done: done=%b ready=%b required done=1 ready=0", b_tx_done, b_ready);
    end
    step();
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fail++; $display("FAIL noack_ready_after_done: got %b required 1", b_ready);
    end
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 400 && b_done_cnt < d0 + 2; i++) step();
    repeat (20) step();
    n_checks++;
    if (b_words.size() != w0 + 2) begin
      n_fail++; $display("FAIL noack_frames: got %0d required 2", b_words.size() - w0);
    end else begin
      n_checks++;
      if (b_words[w0] !== exp0 || b_words[w0 + 1] !== exp1) begin
        n_fail++; $display("FAIL noack_words: got %h %h required %h %h", b_words[w0], b_words[w0 + 1], exp0, exp1);
      end
      n_checks++;
      if (b_lens[w0 + 1] != FRAME_CYC) begin
        n_fail++; $display("FAIL noack_frame_len: got %0d required %0d", b_lens[w0 + 1], FRAME_CYC);
      end
    end
    n_checks++;
    if (b_gap != NOACK_GAP) begin
      n_fail++; $display("FAIL noack_gap: got %0d cycles required %0d", b_gap, NOACK_GAP);
    end
    n_checks++;
    if (b_done_cnt != d0 + 2 || b_err_cnt != e0 || b_busy !== 1'b0 || b_err_count !== 8'd0) begin
      n_fail++; $display("FAIL noack_pulses: done=%0d err=%0d busy=%b err_count=%0d required 2 0 0 0",
        b_done_cnt - d0, b_err_cnt - e0, b_busy, b_err_count);
    end
    n_checks++;
    if (b_idle_viol != 0) begin
      n_fail++; $display("FAIL idle_lines_b: got %0d required 0", b_idle_viol);
    end
  endtask

  task automatic test_reset_mid_packet();
    int d0, e0;
    send_a(4'($urandom_range(0, 15)), 16'($urandom));
    for (int i = 0; i < 50 && a_tx_frame_n; i++) step();
    for (int i = 0; i < 200 && a_nbits < 15; i++) step();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({a_tx_frame_n, a_tx_clk, a_tx_data, a_busy} !== 4'b1000) begin
      n_fail++; $display("FAIL midreset_outputs: frame_n,clk,data,busy=%b required 1000",
        {a_tx_frame_n, a_tx_clk, a_tx_data, a_busy});
    end
    d0 = a_done_cnt; e0 = a_err_cnt;
    step();
    reset_n = 1'b1;
    step();
    n_checks++;
    if (a_ready !== 1'b1 || a_err_count !== 8'd0) begin
      n_fail++; $display("FAIL midreset_ready: ready=%b err_count=%0d required 1 0", a_ready, a_err_count);
    end
    repeat (300) step();
    n_checks++;
    if (a_done_cnt != d0 || a_err_cnt != e0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_dropped: done=%0d err=%0d busy=%b required 0 0 0",
        a_done_cnt - d0, a_err_cnt - e0, a_busy);
    end
  endtask

  task automatic test_saturation();
    int e0, d0;
    e0 = s_err_cnt; d0 = s_done_cnt;
    step();
    s_type = MSG_GAMEOVER; s_payload = 16'($urandom); s_valid = 1'b1;
    for (int i = 0; i < 12000 && s_err_cnt < e0 + 100; i++) step();
    step();
    n_checks++;
    if (s_err_count !== 8'd100) begin
      n_fail++; $display("FAIL err_count_100: got %0d required 100", s_err_count);
    end
    for (int i = 0; i < 20000 && s_err_cnt < e0 + 258; i++) step();
    s_valid = 1'b0;
    for (int i = 0; i < 200 && s_busy; i++) step();
    step();
    n_checks++;
    if (s_err_cnt < e0 + 258) begin
      n_fail++; $display("FAIL sat_error_pulses: got %0d required at least 258", s_err_cnt - e0);
    end
    n_checks++;
    if (s_err_count !== 8'd255) begin
      n_fail++; $display("FAIL err_count_saturate: got %0d required 255", s_err_count);
    end
    n_checks++;
    if (s_done_cnt != d0 || s_ready !== 1'b1 || s_idle_viol != 0) begin
      n_fail++; $display("FAIL sat_misc: done=%0d ready=%b idle_viol=%0d required 0 1 0",
        s_done_cnt - d0, s_ready, s_idle_viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_in_shift();
    test_retry_success();
    test_random_packets();
    test_no_ack();
    test_reset_mid_packet();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
